// File: rtl/flash_seq_pkg.sv
// rtl/flash_seq_pkg.sv - shared state type and width helper for the flash sequencer
package flash_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } fs_state_e;

  // Rate counter width: one bit per non-zero rate select value.
  function automatic int rc_width(input int rate_w);
    return (1 << rate_w) - 1;
  endfunction

endpackage

// File: rtl/flash_seq_pwm.sv
// rtl/flash_seq_pwm.sv - free-running PWM generator for the flash intensity DAC
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   level     in   LVL_W duty numerator (high for `level` of every 2**LVL_W cycles)
//   flash_dac out  registered PWM output
module flash_seq_pwm #(
  parameter int LVL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] level,
  output logic             flash_dac
);

  logic [LVL_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      flash_dac <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + LVL_W'(1);
      flash_dac <= (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/flash_sequencer.sv
// rtl/flash_sequencer.sv - LED flasher burst sequencer with rate select and PWM level output
// Optional feature macro: FLASH_SEQ_CNT_EN (adds flash_count output).
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   one_pps     in   GPS 1PPS, asynchronous (synchronised here)
//   enable      in   run enable; rising edge arms a burst, low forces IDLE
//   ch_mask     in   NCH channels to fire
//   rate        in   trigger select: 0 = 1PPS, r > 0 = rate_count[RC_W-r] rise
//   width       in   pulse length minus 1, in clk cycles
//   level       in   PWM duty numerator
//   burst       in   flashes per burst, 0 = continuous
//   sw_trig     in   single-cycle software trigger
//   flash_dac   out  PWM level output
//   pulse       out  NCH flasher pulses
//   busy        out  high whenever the FSM is not IDLE
//   done        out  one-cycle strobe at the end of a finite burst
//   flash_count out  (FLASH_SEQ_CNT_EN only) count of fired flashes
module flash_sequencer
  import flash_seq_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int LVL_W   = 5,
  parameter int WID_W   = 4,
  parameter int RATE_W  = 3,
  parameter int DIV     = 8192,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               one_pps,
  input  logic               enable,
  input  logic [NCH-1:0]     ch_mask,
  input  logic [RATE_W-1:0]  rate,
  input  logic [WID_W-1:0]   width,
  input  logic [LVL_W-1:0]   level,
  input  logic [BURST_W-1:0] burst,
  input  logic               sw_trig,
  output logic               flash_dac,
  output logic [NCH-1:0]     pulse,
  output logic               busy,
  output logic               done
`ifdef FLASH_SEQ_CNT_EN
  ,
  output logic [31:0]        flash_count
`endif
);

  localparam int RC_W = rc_width(RATE_W);
  localparam int PS_W = (DIV > 2) ? $clog2(DIV) : 1;

  // Prescaler and free-running rate counter
  logic [PS_W-1:0] pre_cnt;
  logic [RC_W-1:0] rate_count;
  logic            pre_wrap;

  assign pre_wrap = (pre_cnt == PS_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      rate_count <= '0;
    end else begin
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PS_W'(1);
      if (pre_wrap) begin
        rate_count <= rate_count + RC_W'(1);
      end
    end
  end

  // Trigger sources: synchronised 1PPS edge, or registered edge of the
  // selected rate counter bit. Both paths present a one-cycle trigger.
  logic pps_meta, pps_sync, pps_last, pps_trig;
  logic sel_bit, sel_last, rate_trig;
  logic en_last, en_rise, trig;

  always_comb begin
    sel_bit = 1'b0;
    for (int r = 1; r <= RC_W; r++) begin
      if (rate == RATE_W'(r)) begin
        sel_bit = rate_count[RC_W-r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pps_meta  <= 1'b0;
      pps_sync  <= 1'b0;
      pps_last  <= 1'b0;
      pps_trig  <= 1'b0;
      sel_last  <= 1'b0;
      rate_trig <= 1'b0;
      en_last   <= 1'b0;
    end else begin
      pps_meta  <= one_pps;
      pps_sync  <= pps_meta;
      pps_last  <= pps_sync;
      pps_trig  <= pps_sync & ~pps_last;
      sel_last  <= sel_bit;
      rate_trig <= sel_bit & ~sel_last;
      en_last   <= enable;
    end
  end

  assign en_rise = enable & ~en_last;
  // Simultaneous software and rate triggers collapse into one flash.
  assign trig    = sw_trig | ((rate == '0) ? pps_trig : rate_trig);

  // Sequencer FSM
  fs_state_e          state, state_d;
  logic [WID_W-1:0]   wcnt, wcnt_d;
  logic [BURST_W-1:0] remaining, remaining_d;
  logic [NCH-1:0]     pulse_d;
  logic               fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      remaining <= '0;
      pulse     <= '0;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      remaining <= remaining_d;
      pulse     <= pulse_d;
    end
  end

  // pulse is registered from the next-state decision so it rises on the
  // same edge that enters PULSE and lasts exactly width+1 cycles.
  // remaining == 0 while running means continuous mode.
  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    remaining_d = remaining;
    pulse_d     = '0;
    done        = 1'b0;
    fire        = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en_rise) begin
            state_d     = ARMED;
            remaining_d = burst;
          end
        end
        ARMED: begin
          if (trig) begin
            state_d = PULSE;
            wcnt_d  = width;
            pulse_d = ch_mask;
            fire    = 1'b1;
          end
        end
        PULSE: begin
          if (wcnt == '0) begin
            state_d = GAP;
          end else begin
            wcnt_d  = wcnt - WID_W'(1);
            pulse_d = pulse;
          end
        end
        GAP: begin
          if (remaining == '0) begin
            state_d = ARMED;
          end else if (remaining == BURST_W'(1)) begin
            remaining_d = '0;
            done        = 1'b1;
            state_d     = IDLE;
          end else begin
            remaining_d = remaining - BURST_W'(1);
            state_d     = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef FLASH_SEQ_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_count <= '0;
    end else if (fire) begin
      flash_count <= flash_count + 32'd1;
    end
  end
`else
  logic unused_fire;
  assign unused_fire = fire;
`endif

  flash_seq_pwm #(
    .LVL_W(LVL_W)
  ) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .level    (level),
    .flash_dac(flash_dac)
  );

endmodule

// File: doc/flash_sequencer.md
Name: flash_sequencer

Overview:
- Parametrised next-generation LED flasher controller for the quabo master FPGA.
- Drives NCH flasher channels with a programmable trigger rate (1PPS or power-of-2 divided clk), pulse width in clk cycles, channel mask and finite/continuous burst count.
- Also produces a PWM level signal for the flash-intensity DAC filter.
- Single clock domain; sits between the register/control interface and the flasher output pins. Any DDR/differential output buffering stays outside this block.

Parameters:
- NCH, 4, number of flasher channels.
- LVL_W, 5, level/PWM counter width.
- WID_W, 4, pulse-width field width.
- RATE_W, 3, rate select width; rate counter width RC_W = 2**RATE_W - 1.
- DIV, 8192, prescaler period in clk cycles, at least 2.
- BURST_W, 8, burst-count field width.

Ports:
- clk, in, 1, system clock (100 MHz nominal).
- rst_n, in, 1, asynchronous active-low reset.
- one_pps, in, 1, GPS 1PPS (asynchronous; synchronised internally).
- enable, in, 1, run enable; a rising edge arms a new burst.
- ch_mask, in, NCH, channels to fire.
- rate, in, RATE_W, trigger source select.
- width, in, WID_W, pulse length minus 1, in clk cycles.
- level, in, LVL_W, PWM duty numerator.
- burst, in, BURST_W, flashes per burst; 0 = continuous.
- sw_trig, in, 1, software trigger, active for one cycle.
- flash_dac, out, 1, PWM level output.
- pulse, out, NCH, flasher pulses.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle strobe at the end of a finite burst.

Behaviour:
- Reset: state IDLE; all counters 0; pulse, busy, done, flash_dac all 0. Takes effect asynchronously; release is synchronous to clk.
- Prescaler: counts 0..DIV-1 and wraps. The rate counter (RC_W bits, wraps freely) increments on the wrap cycle.
- Trigger source:
  - rate == 0: rising edge of one_pps after 2 sync flops plus an edge-detect register.
  - rate == r, r > 0: rising edge of rate_count[RC_W-r], registered.
  - sw_trig is ORed in unregistered in every mode.
- PWM: free-running LVL_W-bit counter; flash_dac is registered as (pwm_cnt < level). level=0 gives constant 0; level = max gives (2**LVL_W - 1)/2**LVL_W duty. Runs in every state.
- FSM states: IDLE, ARMED, PULSE, GAP.
  - IDLE: on an enable rising edge, load remaining = burst and go to ARMED.
  - ARMED: on trigger, latch width and ch_mask, load wcnt = width, go to PULSE.
  - PULSE: pulse = latched mask; wcnt decrements each cycle; at wcnt == 0 go to GAP. Pulse is high for exactly width+1 cycles.
  - GAP: one cycle with pulse = 0.
    - If burst != 0: decrement remaining. If remaining reaches 0, assert done for this cycle and go to IDLE (a new enable edge is needed to re-arm). Otherwise go to ARMED.
    - If burst == 0: go to ARMED.
- Latency: sw_trig high on edge N (state ARMED) gives pulse high on edges N+1 through N+1+width. A one_pps rise sampled at edge N gives pulse high from edge N+4.
- Triggers arriving in IDLE, PULSE or GAP are dropped, not queued.
- enable low in any state: go to IDLE on the next edge; pulse clears the same edge; no done.
- Changes to width or ch_mask during PULSE have no effect until the next trigger.
- Simultaneous sw_trig and rate trigger count as one flash.
- ch_mask == 0 still runs the FSM and counts the flash, with pulse staying 0.

Optional Feature:
- Macro: FLASH_SEQ_CNT_EN.
- When defined: adds output flash_count[31:0], which increments on each ARMED-to-PULSE transition, wraps at 2**32, and resets to 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package flash_seq_pkg: state enum typedef (IDLE, ARMED, PULSE, GAP) and the RC_W derivation function.
- One sub-module, flash_seq_pwm: the level PWM counter and comparator, parametrised by LVL_W.

Test Plan:
- Apply reset mid-PULSE with width=7 → pulse, busy, done are 0 immediately; state is IDLE after release.
- enable rise, burst=3, width=2, ch_mask=4'b0101, three sw_trig pulses 10 cycles apart → three 3-cycle pulses on channels 0 and 2; done for 1 cycle in the third GAP; then IDLE, and a fourth sw_trig is ignored.
- DIV=4, rate=7, burst=0 → trigger every 8 clk cycles (rate_count[0] rise); flash_count advances by 1 per trigger when FLASH_SEQ_CNT_EN is defined.
- rate=0, one_pps pulse at cycle 100, width=0 → pulse high for exactly one cycle at edge 104.
- level=0, then 16, then 31 (LVL_W=5) → flash_dac high for 0, 16 and 31 of every 32 cycles.
- sw_trig asserted during PULSE, and enable dropped during GAP → extra trigger dropped; FSM goes to IDLE with no done.
